// File: rtl/hex_scan_driver_if.sv
// Display bus for hex_scan_driver: value/control inputs and the seg/grid pins.
interface hex_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] In;
    logic [DIGITS-1:0]   dp;
    logic                blank_lz;
    logic                freeze;
    logic [7:0]          hex_seg;
    logic [DIGITS-1:0]   hex_grid;

    modport master (output In, dp, blank_lz, freeze, input hex_seg, hex_grid);
    modport slave  (input In, dp, blank_lz, freeze, output hex_seg, hex_grid);
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver. Values are latched into
// shadow registers only at frame boundaries so a frame never mixes two values.
module hex_scan_driver #(
    parameter int DIGITS          = 4,
    parameter int DIV_BITS        = 16,
    parameter int SEG_ACTIVE_LOW  = 1,
    parameter int GRID_ACTIVE_LOW = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    hex_scan_driver_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]  cnt;
    logic [IDX_W-1:0]     idx;
    logic [4*DIGITS-1:0]  sh_val;
    logic [DIGITS-1:0]    sh_dp;
    logic                 tick;

    assign tick = &cnt;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    // Prescaler, digit scan and frame-boundary shadow capture.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt    <= '0;
            idx    <= '0;
            sh_val <= '0;
            sh_dp  <= '0;
        end else begin
            cnt <= cnt + DIV_BITS'(1);
            if (tick) begin
                if (idx == LAST_IDX) begin
                    idx <= '0;
                    if (!bus.freeze) begin
                        sh_val <= bus.In;
                        sh_dp  <= bus.dp;
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    logic [3:0]        nib;
    logic              dp_bit;
    logic              zero_above;
    logic              blank;
    logic [DIGITS-1:0] grid_raw;
    logic [7:0]        seg_raw;

    // Select the scanned digit and work out leading-zero blanking from the top down.
    always_comb begin
        nib        = 4'h0;
        dp_bit     = 1'b0;
        zero_above = 1'b1;
        blank      = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (sh_val[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) begin
                nib    = sh_val[4*k +: 4];
                dp_bit = sh_dp[k];
                blank  = bus.blank_lz & (k != 0) & zero_above;
            end
        end
    end

    // Drive grid and segments; polarity is applied last.
    always_comb begin
        grid_raw = '0;
        for (int k = 0; k < DIGITS; k++)
            grid_raw[k] = (idx == IDX_W'(k)) & ~blank;
        seg_raw = blank ? 8'h00 : {dp_bit, seg_decode(nib)};
        bus.hex_grid = (GRID_ACTIVE_LOW != 0) ? ~grid_raw : grid_raw;
        bus.hex_seg  = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end
endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench: a cycle-level reference model queues the expected grid/seg
// pair for every clock; a monitor pops and compares on the falling edge.
module tb_hex_scan_driver;
    localparam int DIGITS   = 4;
    localparam int DIV_BITS = 2;
    localparam int DWELL    = 1 << DIV_BITS;
    localparam int FRAME    = DWELL * DIGITS;

    logic Clk = 1'b0;
    logic Reset;

    hex_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    hex_scan_driver #(
        .DIGITS(DIGITS), .DIV_BITS(DIV_BITS),
        .SEG_ACTIVE_LOW(1), .GRID_ACTIVE_LOW(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DIGITS-1:0] grid;
        logic [7:0]        seg;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: clocks since reset decide which digit is lit; the shown
    // value is whatever was presented at the last clock that closed a frame.
    int                  m_clocks = 0;
    logic [4*DIGITS-1:0] m_val = '0;
    logic [DIGITS-1:0]   m_dp  = '0;

    function automatic exp_t model_out(input int clocks, input logic [4*DIGITS-1:0] v,
                                       input logic [DIGITS-1:0] d, input logic blz);
        exp_t e;
        int   dig;
        logic [4*DIGITS-1:0] upper;
        dig   = (clocks / DWELL) % DIGITS;
        upper = v >> (4 * dig);
        if (blz && dig > 0 && upper == '0) begin
            e.grid = '1;
            e.seg  = 8'hFF;
        end else begin
            e.grid = ~(DIGITS'(1) << dig);
            e.seg  = ~{d[dig], seg_tbl[upper[3:0]]};
        end
        return e;
    endfunction

    initial begin
        logic                s_rst, s_frz;
        logic [4*DIGITS-1:0] s_in;
        logic [DIGITS-1:0]   s_dp;
        forever begin
            @(posedge Clk);
            s_rst = Reset; s_frz = bus.freeze; s_in = bus.In; s_dp = bus.dp;
            #4;
            if (!s_rst) begin
                if (m_clocks % FRAME == FRAME - 1 && !s_frz) begin
                    m_val = s_in;
                    m_dp  = s_dp;
                end
                m_clocks++;
            end
            if (Reset) begin
                m_clocks = 0;
                m_val    = '0;
                m_dp     = '0;
            end
            exp_q.push_back(model_out(m_clocks, m_val, m_dp, bus.blank_lz));
        end
    end

    // Monitor: compare the DUT pins against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.hex_grid !== e.grid) begin
                    fails++;
                    $display("FAIL grid t=%0t got %b exp %b", $time, bus.hex_grid, e.grid);
                end
                tests++;
                if (bus.hex_seg !== e.seg) begin
                    fails++;
                    $display("FAIL seg t=%0t got %h exp %h", $time, bus.hex_seg, e.seg);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [DIGITS-1:0] g, input logic [7:0] s);
        tests++;
        if (bus.hex_grid !== g || bus.hex_seg !== s) begin
            fails++;
            $display("FAIL %s t=%0t got grid %b seg %h exp grid %b seg %h",
                     name, $time, bus.hex_grid, bus.hex_seg, g, s);
        end
    endtask

    initial begin
        Reset        = 1'b1;
        bus.In       = '0;
        bus.dp       = '0;
        bus.blank_lz = 1'b0;
        bus.freeze   = 1'b0;
        #1;
        check_now("reset_state", 4'b1110, 8'hC0);
        step(10);
        Reset = 1'b0;

        // Plain value, then a mid-frame change that must not tear the frame.
        bus.In = 16'h12AF;
        step(2 * FRAME);
        step(DWELL + 1);
        bus.In = 16'h0000;
        step(2 * FRAME);

        // Freeze holds through three boundaries, then release with a new value.
        bus.freeze = 1'b1;
        bus.In     = 16'h5555;
        step(3 * FRAME);
        bus.freeze = 1'b0;
        step(2 * FRAME);
        bus.In = 16'h0000;
        bus.dp = 4'b0001;
        step(2 * FRAME);

        // Leading-zero blanking, toggled at odd times to hit the immediate path.
        bus.dp       = '0;
        bus.In       = 16'h0030;
        bus.blank_lz = 1'b1;
        step(2 * FRAME);
        bus.In = 16'h0000;
        step(2 * FRAME + 3);
        bus.blank_lz = 1'b0;
        step(FRAME);

        // Randomized traffic: inputs change at arbitrary clocks.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: bus.In = 16'($urandom);
                1: bus.In = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
                2: bus.dp = 4'($urandom);
                default: begin
                    bus.freeze   = ($urandom_range(0, 3) == 0);
                    bus.blank_lz = 1'($urandom);
                end
            endcase
            step($urandom_range(1, 6));
        end

        // Asynchronous reset between edges in the middle of a frame.
        bus.freeze   = 1'b0;
        bus.blank_lz = 1'b0;
        bus.In       = 16'h12AF;
        step(2 * FRAME);
        step(2 * DWELL + 1);
        #2;
        Reset = 1'b1;
        #1;
        check_now("async_reset", 4'b1110, 8'hC0);
        step(3);
        Reset = 1'b0;
        step(2 * FRAME);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment driver for an N-digit display (the hex_seg/hex_grid pair used by the SLC-3 top level).
- Scans one digit at a time at a programmable refresh rate.
- Updates the displayed value only at frame boundaries, so PC/IR/MDR values never show tearing across digits.
- Adds a freeze (hold) control, per-digit decimal points and optional leading-zero blanking.

Parameters:
DIGITS, 4, number of digits scanned (1..8).
DIV_BITS, 16, prescaler width; one scan tick every 2^DIV_BITS clocks.
SEG_ACTIVE_LOW, 1, 1 = hex_seg bits driven low to light a segment.
GRID_ACTIVE_LOW, 1, 1 = hex_grid bit driven low to enable a digit.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
In  input  4*DIGITS  hex value; nibble k drives digit k (digit 0 = least significant).
dp  input  DIGITS  decimal point request per digit.
blank_lz  input  1  1 = blank leading-zero digits.
freeze  input  1  1 = hold the currently displayed value.
hex_seg  output  8  segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
hex_grid  output  DIGITS  one-hot digit enable, polarity per GRID_ACTIVE_LOW.

Behaviour:
- State registers:
  - prescaler cnt[DIV_BITS-1:0]
  - digit index idx (clog2(DIGITS) bits; 1 bit when DIGITS=1)
  - shadow value sh_val[4*DIGITS-1:0]
  - shadow dp sh_dp[DIGITS-1:0]
- Reset (async, any time, including mid-frame): cnt=0, idx=0, sh_val=0, sh_dp=0. Outputs follow immediately: digit 0 enabled, all other digits disabled, digit 0 shows "0" with dp off (hex_seg=8'hC0 with default parameters).
- Prescaler: cnt increments every clock and wraps from 2^DIV_BITS-1 to 0. tick = (cnt == all-ones).
- Scan: on tick, idx advances by 1; DIGITS-1 wraps to 0. Each digit is therefore enabled for exactly 2^DIV_BITS clocks.
- Frame boundary: tick while idx==DIGITS-1.
  - freeze=0: sh_val<=In and sh_dp<=dp on the same edge that idx wraps to 0.
  - freeze=1: shadows hold.
  - In, dp and freeze are sampled only at that edge. Changes at any other time have no effect on the display.
- Outputs are combinational from registered state only (no path from In, dp or freeze to outputs). They change on the same edge as idx or the shadows.
  - hex_grid: bit idx asserted, all other bits deasserted.
  - hex_seg[6:0]: decode of nibble sh_val[4*idx+:4], active-high before polarity:
    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - hex_seg[7] = sh_dp[idx].
  - Polarity is applied last: the whole byte is inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking (blank_lz=1):
  - Digit k>0 is blanked iff every shadow nibble k..DIGITS-1 is zero.
  - Digit 0 is never blanked.
  - A blanked digit has its grid bit deasserted and all segments off, including dp.
  - blank_lz is combinational on output state and takes effect immediately, not at a frame boundary.
- DIGITS=1: idx is constantly 0 and the frame boundary occurs on every tick.

Test Plan:
(All scenarios use DIGITS=4, DIV_BITS=2, default polarity; tick every 4 clocks.)
1. Reset held 10 clocks, then released. During reset: hex_grid=4'b1110, hex_seg=8'hC0. After release: grid steps 1110→1101→1011→0111→1110, 4 clocks per step.
2. In=16'h12AF, dp=0, freeze=0. After the first frame boundary: digit0=8'h8E (F), digit1=8'h88 (A), digit2=8'hA4 (2), digit3=8'hF9 (1).
3. Change In to 16'h0000 while idx=1. Digits 1..3 still show A,2,1 for the rest of the frame. All digits show 8'hC0 from the next boundary.
4. freeze=1, In=16'h5555 for 3 frames: display is unchanged. Drop freeze: digits show 8'h92 (5) only after the next boundary. Also set dp=4'b0001 with In=0: digit0 hex_seg=8'h40.
5. blank_lz=1 with In=16'h0030 latched: digits 3,2 have grid bit=1 and hex_seg=8'hFF; digit1=8'hB0; digit0=8'hC0. With In=0: only digit0 lit. Deassert blank_lz: digits 3,2 show 8'hC0 immediately.
6. Assert Reset asynchronously mid-frame (between edges, idx=2, sh_val=16'h12AF). Outputs go immediately to digit 0 showing 8'hC0, and the scan restarts from idx=0 after release.
